// File: rtl/marlann_pipeline.sv
// marlann_pipeline: 5-stage in-order MARLANN opcode pipeline (DECODE, MEM, ADD, MULT, WRITE).
// Optional macro PIPE_PERF_CNT_EN adds the retired_cnt instruction counter output.
module marlann_pipeline #(
  parameter int MEM_DEPTH = 16,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       inst,
  output logic [4:0]       stage_valid,
  output logic             busy,
  output logic [ACC_W-1:0] out_data,
`ifdef PIPE_PERF_CNT_EN
  output logic [15:0]      retired_cnt,
`endif
  output logic             out_valid
);

  localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MEM1  = 3'd1;
  localparam logic [2:0] OP_MEM2  = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_WRITE = 3'd5;

  logic [2:0]       op_q  [5];
  logic [2:0]       op_d  [5];
  logic [7:0]       mem_q [MEM_DEPTH];
  logic [7:0]       mem_d [MEM_DEPTH];
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_mul;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] retired_cnt_q, retired_cnt_d;
`endif

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      stage_valid[k] = (op_q[k] != OP_NOP);
    end
    busy = |stage_valid;
  end

  always_comb begin
    op_d        = op_q;
    mem_d       = mem_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    acc_mul     = acc_q;

    if (rst) begin
      for (int k = 0; k < 5; k++) op_d[k] = OP_NOP;
      for (int k = 0; k < MEM_DEPTH; k++) mem_d[k] = 8'(k + 1);
      a_d        = '0;
      b_d        = '0;
      acc_d      = '0;
      ptr_d      = '0;
      out_data_d = '0;
    end else begin
      op_d[0] = (inst <= 8'h05) ? inst[2:0] : OP_NOP;
      for (int k = 1; k < 5; k++) op_d[k] = op_q[k-1];

      if (op_q[1] == OP_MEM1) begin
        a_d   = mem_q[ptr_q];
        ptr_d = ptr_q + 1'b1;
      end else if (op_q[1] == OP_MEM2) begin
        b_d   = mem_q[ptr_q];
        ptr_d = ptr_q + 1'b1;
      end

      // MULT is the older instruction, so it applies before a same-cycle ADD.
      if (op_q[3] == OP_MULT) acc_mul = acc_q * ACC_W'(b_q);
      acc_d = acc_mul;
      if (op_q[2] == OP_ADD) acc_d = acc_mul + ACC_W'(a_q);

      if (op_q[4] == OP_WRITE) begin
        out_data_d  = acc_q;
        out_valid_d = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (rst) retired_cnt_d = '0;
    else if (op_q[4] != OP_NOP) retired_cnt_d = retired_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) retired_cnt_q <= retired_cnt_d;

  assign retired_cnt = retired_cnt_q;
`endif

  always_ff @(posedge clk) begin
    op_q        <= op_d;
    mem_q       <= mem_d;
    a_q         <= a_d;
    b_q         <= b_d;
    acc_q       <= acc_d;
    ptr_q       <= ptr_d;
    out_data_q  <= out_data_d;
    out_valid_q <= out_valid_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_marlann_pipeline.sv
// Self-checking bench for marlann_pipeline against a behavioural model of the opcode stages.
// Honours PIPE_PERF_CNT_EN to also check retired_cnt.
module tb_marlann_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inst;
  logic [4:0]  stage_valid;
  logic        busy;
  logic [15:0] out_data;
  logic        out_valid;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  int  m_hist [5];   // opcode occupying stage k (k edges after it was sampled)
  int  m_mem  [16];
  int  m_a, m_b, m_acc, m_ptr, m_out;
  bit  m_ov;
  int  m_ret;

  always #5 clk = ~clk;

  marlann_pipeline dut (
    .clk         (clk),
    .rst         (rst),
    .inst        (inst),
    .stage_valid (stage_valid),
    .busy        (busy),
    .out_data    (out_data),
`ifdef PIPE_PERF_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .out_valid   (out_valid)
  );

  function automatic logic [4:0] m_sv();
    logic [4:0] v;
    for (int k = 0; k < 5; k++) v[k] = (m_hist[k] != 0);
    return v;
  endfunction

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic model_edge(input logic [7:0] x, input bit r);
    int acc_n;
    if (r) begin
      for (int k = 0; k < 5; k++) m_hist[k] = 0;
      for (int k = 0; k < 16; k++) m_mem[k] = k + 1;
      m_a = 0; m_b = 0; m_acc = 0; m_ptr = 0; m_out = 0; m_ov = 0; m_ret = 0;
      return;
    end
    m_ov = (m_hist[4] == 5);
    if (m_ov) m_out = m_acc;
    if (m_hist[4] != 0) m_ret = (m_ret + 1) % 65536;
    acc_n = m_acc;
    if (m_hist[3] == 4) acc_n = (acc_n * m_b) % 65536;
    if (m_hist[2] == 3) acc_n = (acc_n + m_a) % 65536;
    m_acc = acc_n;
    if (m_hist[1] == 1 || m_hist[1] == 2) begin
      if (m_hist[1] == 1) m_a = m_mem[m_ptr];
      else m_b = m_mem[m_ptr];
      m_ptr = (m_ptr + 1) % 16;
    end
    for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = (x <= 8'h05) ? int'(x) : 0;
  endtask

  task automatic tick(input logic [7:0] x, input bit r);
    inst = x;
    rst  = r;
    @(posedge clk);
    model_edge(x, r);
    #1;
  endtask

  task automatic test_reset();
    tick(8'h05, 1'b1);
    tick(8'h00, 1'b1);
    checks++;
    if ({out_valid, out_data, stage_valid, busy} !== {1'b0, 16'h0, 5'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got ov=%0b od=%h sv=%b busy=%0b want all zero",
               out_valid, out_data, stage_valid, busy);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (retired_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_retired got %0d want 0", retired_cnt);
    end
`endif
  endtask

  task automatic test_first_sequence();
    logic [7:0] seq [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int pulses = 0, pulse_at = -1;
    logic [15:0] cap = 16'hxxxx;
    for (int i = 0; i < 12; i++) begin
      tick(seq[i], 1'b0);
      checks++;
      if ({out_valid, out_data, stage_valid, busy} !== {m_ov, 16'(m_out), m_sv(), |m_sv()}) begin
        errors++;
        $display("FAIL seq_cycle%0d got ov=%0b od=%h sv=%b busy=%0b want ov=%0b od=%h sv=%b",
                 i, out_valid, out_data, stage_valid, busy, m_ov, 16'(m_out), m_sv());
      end
      if (out_valid) begin
        pulses++; pulse_at = i; cap = out_data;
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != 9 || cap !== 16'h0002) begin
      errors++;
      $display("FAIL seq_result got pulses=%0d at=%0d data=%h want 1 at 9 data 0002",
               pulses, pulse_at, cap);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (retired_cnt !== 16'd5) begin
      errors++;
      $display("FAIL seq_retired got %0d want 5", retired_cnt);
    end
`endif
  endtask

  task automatic test_mem_walk();
    logic [7:0] seq [11] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 11; i++) begin
      tick(seq[i], 1'b0);
      checks++;
      if ({out_valid, stage_valid, busy} !== {1'b0, m_sv(), |m_sv()}) begin
        errors++;
        $display("FAIL walk_cycle%0d got ov=%0b sv=%b busy=%0b want ov=0 sv=%b",
                 i, out_valid, stage_valid, busy, m_sv());
      end
    end
    checks++;
    if (m_ptr != 4 || m_a != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL walk_end got model ptr=%0d a=%0d busy=%0b want 4 4 0", m_ptr, m_a, busy);
    end
  endtask

  task automatic test_ptr_wrap();
    logic [15:0] cap = 16'hxxxx;
    tick(8'h00, 1'b1);
    for (int i = 0; i < 17; i++) tick(8'h01, 1'b0);
    tick(8'h00, 1'b0); tick(8'h00, 1'b0);
    tick(8'h03, 1'b0);
    tick(8'h00, 1'b0); tick(8'h00, 1'b0);
    tick(8'h05, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(8'h00, 1'b0);
      if (out_valid) cap = out_data;
    end
    checks++;
    if (cap !== 16'h0001) begin
      errors++;
      $display("FAIL ptr_wrap got out_data=%h want 0001", cap);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] seq [11] = '{8'hFF, 8'h05, 8'hFF, 8'hFF, 8'h05, 8'h06,
                             8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
    int pulses = 0;
    tick(8'h00, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick(seq[i], 1'b0);
      checks++;
      if ({out_valid, out_data, stage_valid} !== {m_ov, 16'(m_out), m_sv()}) begin
        errors++;
        $display("FAIL illegal_cycle%0d got ov=%0b od=%h sv=%b want ov=%0b od=%h sv=%b",
                 i, out_valid, out_data, stage_valid, m_ov, 16'(m_out), m_sv());
      end
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 2 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL illegal_result got pulses=%0d od=%h want 2 0000", pulses, out_data);
    end
  endtask

  task automatic test_mult_add();
    logic [7:0] seq [22] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03,
                             8'h01, 8'h00, 8'h00, 8'h04, 8'h03, 8'h00, 8'h00,
                             8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [15:0] cap = 16'hxxxx;
    tick(8'h00, 1'b1);
    for (int i = 0; i < 22; i++) begin
      tick(seq[i], 1'b0);
      checks++;
      if ({out_valid, out_data} !== {m_ov, 16'(m_out)}) begin
        errors++;
        $display("FAIL multadd_cycle%0d got ov=%0b od=%h want ov=%0b od=%h",
                 i, out_valid, out_data, m_ov, 16'(m_out));
      end
      if (out_valid) cap = out_data;
    end
    checks++;
    if (cap !== 16'd13) begin
      errors++;
      $display("FAIL multadd_result got %0d want 13", cap);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int pulses = 0;
    tick(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) tick(seq[i], 1'b0);
    tick(8'h05, 1'b0); tick(8'h00, 1'b0); tick(8'h00, 1'b0); tick(8'h00, 1'b0);
    tick(8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(8'h00, 1'b0);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || out_data !== 16'h0 || stage_valid !== 5'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got pulses=%0d od=%h sv=%b busy=%0b want 0 0000 00000 0",
               pulses, out_data, stage_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] x;
    bit r;
    tick(8'h00, 1'b1);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    x = 8'h00;
        2:       x = 8'h01;
        3:       x = 8'h02;
        4, 5:    x = 8'h03;
        6, 7:    x = 8'h04;
        8:       x = 8'h05;
        default: x = 8'($urandom_range(6, 255));
      endcase
      r = ($urandom_range(0, 99) == 0);
      tick(x, r);
      checks++;
      if ({out_valid, out_data, stage_valid, busy} !== {m_ov, 16'(m_out), m_sv(), |m_sv()}) begin
        errors++;
        $display("FAIL random_cycle%0d got ov=%0b od=%h sv=%b busy=%0b want ov=%0b od=%h sv=%b",
                 i, out_valid, out_data, stage_valid, busy, m_ov, 16'(m_out), m_sv());
      end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (retired_cnt !== 16'(m_ret)) begin
        errors++;
        $display("FAIL random_retired%0d got %0d want %0d", i, retired_cnt, m_ret);
      end
`endif
    end
  endtask

  initial begin
    rst  = 1'b1;
    inst = 8'h00;
    for (int k = 0; k < 5; k++) m_hist[k] = 0;
    test_reset();
    test_first_sequence();
    test_mem_walk();
    test_ptr_wrap();
    test_illegal();
    test_mult_add();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
